// File: rtl/synth_out_pkg.sv
// Shared types and default geometry for the synth I2S output stage.
package synth_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MUTE = 2'd2
  } out_state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int SLOT_W_DEF   = 32;
  localparam int BCLK_DIV_DEF = 4;
  localparam int FRAME_BITS   = 2 * SLOT_W_DEF;

  // Counter width that stays at least one bit for tiny ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_sound_out_if.sv
// Mixer-side sample bus and codec-side I2S/status signals of the output stage.
interface i2s_sound_out_if
  import synth_out_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] lsound_in;
  logic [DATA_W-1:0] rsound_in;
  logic              sample_stb;
  logic              mute;
  logic              oAUD_BCK;
  logic              oAUD_LRCK;
  logic              oAUD_DATA;
  logic              frame_tick;
  logic              underrun;
  logic              overrun;

  modport master (
    output lsound_in, rsound_in, sample_stb, mute,
    input  oAUD_BCK, oAUD_LRCK, oAUD_DATA, frame_tick, underrun, overrun
  );

  modport slave (
    input  lsound_in, rsound_in, sample_stb, mute,
    output oAUD_BCK, oAUD_LRCK, oAUD_DATA, frame_tick, underrun, overrun
  );
endinterface

// File: rtl/i2s_bit_timer.sv
// BCK divider and frame bit counter; fall marks the engine cycle whose edge drops BCK.
module i2s_bit_timer
  import synth_out_pkg::*;
#(
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF,
  localparam int FB      = 2 * SLOT_W,
  localparam int BW      = cnt_w(FB),
  localparam int DW      = cnt_w(BCLK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          bck,
  output logic          lrck,
  output logic          fall,
  output logic          frame_start,
  output logic [BW-1:0] bit_idx
);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [BW-1:0] bit_next;

  always_comb begin
    fall        = (div_cnt == DW'(BCLK_DIV - 1));
    div_next    = fall ? '0 : div_cnt + 1'b1;
    frame_start = fall && (bit_idx == BW'(FB - 1));
    bit_next    = bit_idx;
    if (fall) bit_next = (bit_idx == BW'(FB - 1)) ? '0 : bit_idx + 1'b1;
  end

  // BCK and LRCK are registered so they leave the block glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_idx <= '0;
      bck     <= 1'b0;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      bck     <= (div_next >= DW'(BCLK_DIV / 2));
      if (fall) begin
        bit_idx <= bit_next;
        lrck    <= (bit_next >= BW'(SLOT_W));
      end
    end
  end

endmodule

// File: rtl/i2s_sound_out.sv
// Synth output stage: double-buffers mixer L/R samples and serialises them as I2S.
//  state | meaning
//  IDLE  | no sample seen since reset, frames carry zeros, no underrun reporting
//  RUN   | streaming pending samples, repeating the last frame on underrun
//  MUTE  | frames forced to zero, pending samples still consumed
module i2s_sound_out
  import synth_out_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF,
  localparam int BW      = cnt_w(2 * SLOT_W)
) (
  input  logic           sCLK_XVXENVS,
  input  logic           iRST_N,
  i2s_sound_out_if.slave aud
);

  logic          bck;
  logic          lrck;
  logic          fall;
  logic          frame_start;
  logic [BW-1:0] bit_idx;

  i2s_bit_timer #(
    .SLOT_W  (SLOT_W),
    .BCLK_DIV(BCLK_DIV)
  ) u_timer (
    .clk        (sCLK_XVXENVS),
    .rst_n      (iRST_N),
    .bck        (bck),
    .lrck       (lrck),
    .fall       (fall),
    .frame_start(frame_start),
    .bit_idx    (bit_idx)
  );

  out_state_t        state;
  logic [DATA_W-1:0] pend_l;
  logic [DATA_W-1:0] pend_r;
  logic [DATA_W-1:0] shift_l;
  logic [DATA_W-1:0] shift_r;
  logic              pend_valid;
  logic              data;
  logic              tick;
  logic              und;
  logic              ovr;
  logic              in_left;
  logic              in_right;

  // Windows are judged on the bit index being left, giving the one-BCK I2S delay.
  assign in_left  = (bit_idx < BW'(DATA_W));
  assign in_right = (bit_idx >= BW'(SLOT_W)) && (bit_idx < BW'(SLOT_W + DATA_W));

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      pend_l     <= '0;
      pend_r     <= '0;
      pend_valid <= 1'b0;
      shift_l    <= '0;
      shift_r    <= '0;
      data       <= 1'b0;
      tick       <= 1'b0;
      und        <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      tick <= 1'b0;
      und  <= 1'b0;
      ovr  <= aud.sample_stb && pend_valid && !frame_start;

      if (aud.sample_stb) begin
        pend_l     <= aud.lsound_in;
        pend_r     <= aud.rsound_in;
        pend_valid <= 1'b1;
      end else if (frame_start) begin
        pend_valid <= 1'b0;
      end

      // Shifters rotate, so a full word returns them to the loaded value for repeats.
      if (fall) begin
        if (in_left) begin
          data    <= shift_l[DATA_W-1];
          shift_l <= {shift_l[DATA_W-2:0], shift_l[DATA_W-1]};
        end else if (in_right) begin
          data    <= shift_r[DATA_W-1];
          shift_r <= {shift_r[DATA_W-2:0], shift_r[DATA_W-1]};
        end else begin
          data <= 1'b0;
        end
      end

      if (frame_start) begin
        tick <= 1'b1;
        if (state == IDLE) begin
          if (pend_valid) begin
            shift_l <= pend_l;
            shift_r <= pend_r;
            state   <= RUN;
          end
        end else if (aud.mute) begin
          shift_l <= '0;
          shift_r <= '0;
          state   <= MUTE;
        end else begin
          // Leaving MUTE takes effect on this same load, symmetric with entering it.
          state <= RUN;
          if (pend_valid) begin
            shift_l <= pend_l;
            shift_r <= pend_r;
          end else begin
            und <= 1'b1;
          end
        end
      end
    end
  end

  assign aud.oAUD_BCK   = bck;
  assign aud.oAUD_LRCK  = lrck;
  assign aud.oAUD_DATA  = data;
  assign aud.frame_tick = tick;
  assign aud.underrun   = und;
  assign aud.overrun    = ovr;

endmodule

// File: tb/tb_i2s_sound_out.sv
// Directed bench for i2s_sound_out with a frame-level behavioural model checked every cycle.
module tb_i2s_sound_out;

  localparam int DATA_W   = 16;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_sound_out_if #(.DATA_W(DATA_W)) aud ();

  i2s_sound_out #(
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W),
    .BCLK_DIV(BCLK_DIV)
  ) dut (
    .sCLK_XVXENVS(clk),
    .iRST_N      (rst_n),
    .aud         (aud)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;
  int tick_cnt = 0;
  int und_cnt  = 0;
  int ovr_cnt  = 0;

  logic [15:0] m_pl, m_pr, m_wl, m_wr;
  bit          m_pv;
  int          m_mode;   // 0 idle, 1 streaming, 2 muted
  bit          e_tick, e_und, e_ovr;
  bit          s_stb, s_mute;
  logic [15:0] s_l, s_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: actual=%h required=%h", name, n, act, exp);
    end
  endtask

  function automatic logic exp_data(input int b, input logic [15:0] wl, input logic [15:0] wr);
    if (b >= 1 && b <= DATA_W) return wl[DATA_W - b];
    if (b >= SLOT_W + 1 && b <= SLOT_W + DATA_W) return wr[DATA_W - (b - SLOT_W)];
    return 1'b0;
  endfunction

  // Model: n counts engine edges since reset release; a frame is 256 edges.
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; m_pv = 0; m_pl = '0; m_pr = '0; m_wl = '0; m_wr = '0; m_mode = 0;
    end else begin
      s_stb = aud.sample_stb; s_l = aud.lsound_in; s_r = aud.rsound_in; s_mute = aud.mute;
      n++;
      e_tick = (n % 256 == 0);
      e_und  = 0;
      e_ovr  = s_stb && m_pv && !e_tick;
      if (e_tick) begin
        if (m_mode == 0) begin
          if (m_pv) begin m_wl = m_pl; m_wr = m_pr; m_pv = 0; m_mode = 1; end
        end else if (s_mute) begin
          m_wl = '0; m_wr = '0; m_pv = 0; m_mode = 2;
        end else begin
          m_mode = 1;
          if (m_pv) begin m_wl = m_pl; m_wr = m_pr; m_pv = 0; end
          else e_und = 1;
        end
      end
      if (s_stb) begin m_pl = s_l; m_pr = s_r; m_pv = 1; end
      #1;
      if (rst_n) begin
        check("bck",   aud.oAUD_BCK,   32'((n % 4) >= 2));
        check("lrck",  aud.oAUD_LRCK,  32'(((n / 4) % 64) >= 32));
        check("data",  aud.oAUD_DATA,  32'(exp_data((n / 4) % 64, m_wl, m_wr)));
        check("tick",  aud.frame_tick, 32'(e_tick));
        check("under", aud.underrun,   32'(e_und));
        check("over",  aud.overrun,    32'(e_ovr));
        if (aud.frame_tick) tick_cnt++;
        if (aud.underrun)   und_cnt++;
        if (aud.overrun)    ovr_cnt++;
      end
    end
  end

  task automatic wait_n(input int target);
    int g = 0;
    while (n < target && g < 20000) begin @(negedge clk); g++; end
    if (n < target) begin
      n_tests++; n_fail++;
      $display("FAIL wait_n timeout: actual=%0d required=%0d", n, target);
    end
  endtask

  task automatic strobe_at(input int at, input logic [15:0] l, input logic [15:0] r);
    wait_n(at);
    aud.sample_stb = 1'b1; aud.lsound_in = l; aud.rsound_in = r;
    @(negedge clk);
    aud.sample_stb = 1'b0;
  endtask

  task automatic lit(input string name, input int at, input logic act_sel, input logic exp);
    wait_n(at);
    check(name, (act_sel ? aud.oAUD_LRCK : aud.oAUD_DATA), 32'(exp));
  endtask

  initial begin
    aud.sample_stb = 1'b0; aud.lsound_in = '0; aud.rsound_in = '0; aud.mute = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bck",  aud.oAUD_BCK, 0);
    check("rst_lrck", aud.oAUD_LRCK, 0);
    check("rst_data", aud.oAUD_DATA, 0);
    check("rst_pulses", {aud.frame_tick, aud.underrun, aud.overrun}, 0);
    rst_n = 1'b1;

    wait_n(800);
    check("idle_ticks", tick_cnt, 3);
    check("idle_under", und_cnt, 0);

    strobe_at(800, 16'h8001, 16'h7FFE);
    lit("L_b1", 1028, 0, 1'b1);
    lit("L_b2", 1032, 0, 1'b0);
    lit("L_b16", 1088, 0, 1'b1);
    lit("L_b17", 1092, 0, 1'b0);
    strobe_at(1100, 16'h1234, 16'hABCD);
    lit("lrck_b31", 1151, 1, 1'b0);
    lit("lrck_b32", 1152, 1, 1'b1);
    lit("R_b33", 1156, 0, 1'b0);
    lit("R_b34", 1160, 0, 1'b1);
    lit("R_b48", 1216, 0, 1'b0);
    lit("R_b49", 1220, 0, 1'b0);

    wait_n(1540);
    check("underrun_once", und_cnt, 1);
    lit("repeat_b3", 1548, 0, 1'b0);
    lit("repeat_b4", 1552, 0, 1'b1);

    strobe_at(1600, 16'h1111, 16'h2222);
    strobe_at(1650, 16'h5A5A, 16'hA5A5);
    wait_n(1700);
    check("overrun_once", ovr_cnt, 1);
    lit("B_b2", 1800, 0, 1'b1);

    strobe_at(1900, 16'h0F0F, 16'hF0F0);
    strobe_at(2047, 16'h3C3C, 16'hC3C3);
    lit("C_b4", 2064, 0, 1'b0);
    lit("C_b5", 2068, 0, 1'b1);
    wait_n(2100);
    check("load_edge_no_over", ovr_cnt, 1);

    strobe_at(2400, 16'h6666, 16'h9999);
    wait_n(2450);
    aud.mute = 1'b1;
    lit("mute_midframe", 2468, 0, 1'b1);
    strobe_at(2700, 16'hFFFF, 16'hFFFF);
    lit("muted_b1", 2820, 0, 1'b0);
    wait_n(2900);
    aud.mute = 1'b0;
    strobe_at(2950, 16'hC000, 16'h0003);
    lit("unmute_b1", 3076, 0, 1'b1);
    strobe_at(3100, 16'h4321, 16'h8765);

    wait_n(3154);
    check("pre_rst_bck", aud.oAUD_BCK, 1);
    rst_n = 1'b0;
    #1;
    check("async_bck",  aud.oAUD_BCK, 0);
    check("async_lrck", aud.oAUD_LRCK, 0);
    check("async_data", aud.oAUD_DATA, 0);
    check("async_tick", aud.frame_tick, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_n(255);
    check("post_rst_no_tick", aud.frame_tick, 0);
    wait_n(256);
    check("post_rst_tick", aud.frame_tick, 1);
    wait_n(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
